// File: rtl/camera_frame_classifier.sv
// OV7670 RGB565 capture into the frame buffer with red/blue pixel classification and a per-frame verdict.
// Optional counting window enabled by defining CAM_ROI_EN.
module camera_frame_classifier #(
    parameter int WIDTH     = 176,
    parameter int HEIGHT    = 144,
    parameter int ADDR_W    = 15,
    parameter int CNT_W     = 16,
    parameter int RED_R     = 31,
    parameter int RED_G     = 8,
    parameter int RED_B     = 8,
    parameter int BLUE_R    = 1,
    parameter int BLUE_G    = 1,
    parameter int BLUE_B    = 5,
    parameter int RED_TH    = 17,
    parameter int BLUE_TH   = 12,
    parameter int MIN_COUNT = 6,
    parameter int ROI_X0    = 30,
    parameter int ROI_X1    = 149,
    parameter int ROI_Y0    = 20,
    parameter int ROI_Y1    = 129
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_cam_data,
    input  logic              i_href,
    input  logic              i_vsync,
    input  logic              i_result_ack,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic [1:0]        o_wr_class,
    output logic              o_result_valid,
    output logic [1:0]        o_result_class,
    output logic [CNT_W-1:0]  o_red_count,
    output logic [CNT_W-1:0]  o_blue_count,
    output logic              o_overrun
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);

    typedef enum logic {S_WAIT_FRAME, S_ACTIVE} state_t;

    state_t            r_state;
    logic              r_vsync_d, r_href_d, r_phase;
    logic [7:0]        r_lo;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_red, r_blue;

    function automatic logic [6:0] absdiff(input logic [4:0] a, input logic [4:0] b);
        logic [6:0] d;
        d = {2'b00, a} - {2'b00, b};
        return d[6] ? 7'(-d) : d;
    endfunction

    logic [15:0] w_pix;
    logic        w_red, w_blue, w_in_frame, w_count_ok;
    logic [1:0]  w_class, w_verdict;
    logic        w_vs_rise, w_vs_fall, w_href_fall;

    assign w_pix       = {i_cam_data, r_lo};
    assign w_vs_rise   = i_vsync & ~r_vsync_d;
    assign w_vs_fall   = ~i_vsync & r_vsync_d;
    assign w_href_fall = ~i_href & r_href_d;

    // G compared on the top 5 bits of its 6-bit field
    assign w_red  = (absdiff(w_pix[15:11], 5'(RED_R)) < 7'(RED_TH)) &&
                    (absdiff(w_pix[10:6],  5'(RED_G)) < 7'(RED_TH)) &&
                    (absdiff(w_pix[4:0],   5'(RED_B)) < 7'(RED_TH));
    assign w_blue = (absdiff(w_pix[15:11], 5'(BLUE_R)) < 7'(BLUE_TH)) &&
                    (absdiff(w_pix[10:6],  5'(BLUE_G)) < 7'(BLUE_TH)) &&
                    (absdiff(w_pix[4:0],   5'(BLUE_B)) < 7'(BLUE_TH));
    assign w_class    = w_red ? 2'b01 : (w_blue ? 2'b10 : 2'b00);
    assign w_in_frame = (r_x < XW'(WIDTH)) && (r_y < YW'(HEIGHT));

`ifdef CAM_ROI_EN
    assign w_count_ok = (32'(r_x) >= 32'(ROI_X0)) && (32'(r_x) <= 32'(ROI_X1)) &&
                        (32'(r_y) >= 32'(ROI_Y0)) && (32'(r_y) <= 32'(ROI_Y1));
`else
    assign w_count_ok = 1'b1;
`endif

    assign w_verdict = (r_red >= CNT_W'(MIN_COUNT) && r_red >= r_blue) ? 2'b01 :
                       (r_blue >= CNT_W'(MIN_COUNT))                    ? 2'b10 : 2'b00;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_WAIT_FRAME;
            r_vsync_d      <= 1'b0;
            r_href_d       <= 1'b0;
            r_phase        <= 1'b0;
            r_lo           <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_base         <= '0;
            r_red          <= '0;
            r_blue         <= '0;
            o_wr_en        <= 1'b0;
            o_wr_addr      <= '0;
            o_wr_data      <= '0;
            o_wr_class     <= '0;
            o_result_valid <= 1'b0;
            o_result_class <= '0;
            o_red_count    <= '0;
            o_blue_count   <= '0;
            o_overrun      <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
            r_href_d  <= i_href;
            o_wr_en   <= 1'b0;
            if (o_result_valid && i_result_ack)
                o_result_valid <= 1'b0;
            case (r_state)
                // Entry needs VSYNC seen high first, so a reset mid-frame waits for a whole new frame
                S_WAIT_FRAME: if (w_vs_fall) begin
                    r_state <= S_ACTIVE;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_base  <= '0;
                    r_phase <= 1'b0;
                    r_red   <= '0;
                    r_blue  <= '0;
                end
                S_ACTIVE: if (w_vs_rise) begin
                    r_state        <= S_WAIT_FRAME;
                    o_result_valid <= 1'b1;
                    o_result_class <= w_verdict;
                    o_red_count    <= r_red;
                    o_blue_count   <= r_blue;
                    if (o_result_valid && !i_result_ack)
                        o_overrun <= 1'b1;
                end else if (i_href) begin
                    if (!r_phase) begin
                        r_lo    <= i_cam_data;
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (r_x != XW'(WIDTH))
                            r_x <= r_x + 1'b1;
                        if (w_in_frame) begin
                            o_wr_en    <= 1'b1;
                            o_wr_addr  <= r_base + ADDR_W'(r_x);
                            o_wr_data  <= w_pix;
                            o_wr_class <= w_class;
                            if (w_count_ok && w_class == 2'b01 && r_red != '1)
                                r_red <= r_red + 1'b1;
                            if (w_count_ok && w_class == 2'b10 && r_blue != '1)
                                r_blue <= r_blue + 1'b1;
                        end
                    end
                end else if (w_href_fall) begin
                    r_x     <= '0;
                    r_phase <= 1'b0;
                    if (r_y != YW'(HEIGHT)) begin
                        r_y    <= r_y + 1'b1;
                        r_base <= r_base + ADDR_W'(WIDTH);
                    end
                end
                default: r_state <= S_WAIT_FRAME;
            endcase
        end
    end
endmodule

// File: tb/tb_camera_frame_classifier.sv
// Directed bench: scoreboard of expected frame-buffer writes plus per-frame verdict checks.
module tb_camera_frame_classifier;
    localparam int W = 176, H = 144;

    logic        clk = 0, rst = 1;
    logic [7:0]  cam = 0;
    logic        href = 0, vsync = 1, ack = 0;
    logic        wr_en, res_valid, overrun;
    logic [14:0] wr_addr;
    logic [15:0] wr_data, red_cnt, blue_cnt;
    logic [1:0]  wr_class, res_class;

    camera_frame_classifier dut (
        .i_clk(clk), .i_rst(rst), .i_cam_data(cam), .i_href(href), .i_vsync(vsync),
        .i_result_ack(ack), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_wr_class(wr_class), .o_result_valid(res_valid), .o_result_class(res_class),
        .o_red_count(red_cnt), .o_blue_count(blue_cnt), .o_overrun(overrun));

    always #5 clk = ~clk;

    typedef struct { logic [14:0] addr; logic [15:0] data; logic [1:0] cls; } wr_t;
    wr_t q[$];
    int errors = 0, checks = 0;
    int n_writes = 0;
    logic [14:0] last_addr = 0;
    int exp_red, exp_blue;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_en) begin
            n_writes++;
            last_addr = wr_addr;
            if (q.size() == 0) chk("unexpected_write", 32'(wr_addr), 32'h7fff_ffff);
            else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("wr_class", 32'(wr_class), 32'(e.cls));
            end
        end
    end

    function automatic bit in_roi(int x, int y);
`ifdef CAM_ROI_EN
        return x >= 30 && x <= 149 && y >= 20 && y <= 129;
`else
        return 1;
`endif
    endfunction

    // kind 0: all red; kind 1: 10 blue, 5 red, then green (no class)
    task automatic pix_of(input int kind, input int idx, output logic [15:0] p, output logic [1:0] c);
        if (kind == 0 || (idx >= 10 && idx < 15)) begin p = 16'hF908; c = 2'b01; end
        else if (idx < 10) begin p = 16'h0825; c = 2'b10; end
        else begin p = 16'h07E0; c = 2'b00; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam = b; href = 1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        href = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_row(input int y, input int x0, input int cols, input int kind,
                            inout int idx, input bit expect_wr);
        logic [15:0] p;
        logic [1:0]  c;
        for (int x = x0; x < cols; x++) begin
            pix_of(kind, idx, p, c);
            idx++;
            send_byte(p[7:0]);
            if (expect_wr && x < W && y < H) begin
                q.push_back('{addr: 15'(y * W + x), data: p, cls: c});
                if (in_roi(x, y) && c == 2'b01) exp_red++;
                if (in_roi(x, y) && c == 2'b10) exp_blue++;
            end
            send_byte(p[15:8]);
        end
        idle(4);
    endtask

    task automatic start_frame();
        exp_red = 0; exp_blue = 0;
        vsync = 0;
        idle(3);
    endtask

    task automatic run_frame(input int rows, input int cols, input int kind);
        int idx = 0;
        start_frame();
        for (int y = 0; y < rows; y++) send_row(y, 0, cols, kind, idx, 1);
    endtask

    task automatic end_frame(input bit ack_now, input logic exp_ovr, input string tag);
        logic [1:0] ec;
        vsync = 1; ack = ack_now;
        @(posedge clk); #1;
        ack = 0;
        if (exp_red >= 6 && exp_red >= exp_blue) ec = 2'b01;
        else if (exp_blue >= 6) ec = 2'b10;
        else ec = 2'b00;
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_class"}, 32'(res_class), 32'(ec));
        chk({tag, "_red"}, 32'(red_cnt), 32'(exp_red));
        chk({tag, "_blue"}, 32'(blue_cnt), 32'(exp_blue));
        chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        chk({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
    endtask

    task automatic do_ack(input string tag);
        ack = 1;
        @(posedge clk); #1;
        ack = 0;
        chk(tag, 32'(res_valid), 32'd0);
    endtask

    initial begin
        int idx;
        #12;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_class", 32'(res_class), 32'd0);
        chk("rst_counts", {red_cnt, blue_cnt}, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        idle(3);

        // Oversize solid-red frame: 200x150 in, 176x144 kept
        n_writes = 0;
        run_frame(150, 200, 0);
        chk("big_writes", 32'(n_writes), 32'(W * H));
        chk("big_last_addr", 32'(last_addr), 32'(W * H - 1));
        end_frame(0, 0, "big");
        do_ack("big_ack_clears_valid");

        // 10 blue + 5 red
        run_frame(3, 5, 1);
        end_frame(0, 0, "mix");

        // Second verdict without ack: overwritten, overrun set
        run_frame(1, 8, 0);
        end_frame(0, 1, "ovr");
        do_ack("ovr_ack");

        // Same again but ack in the frame-end cycle
        rst = 1; @(posedge clk); #1; rst = 0;
        chk("rst2_overrun", 32'(overrun), 32'd0);
        idle(2);
        run_frame(1, 8, 0);
        end_frame(0, 0, "d1");
        run_frame(1, 7, 0);
        end_frame(1, 0, "d2");

        // Reset mid-row with a verdict pending
        idx = 0;
        start_frame();
        send_row(0, 0, 3, 0, idx, 1);
        send_byte(8'h08);
        rst = 1; #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_counts", {red_cnt, blue_cnt}, 32'd0);
        chk("mid_rst_class", 32'(res_class), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        #1 rst = 0;
        send_byte(8'hF9);
        send_row(0, 1, 5, 0, idx, 0);
        send_row(1, 0, 5, 0, idx, 0);
        vsync = 1;
        idle(3);
        chk("mid_rst_no_verdict", 32'(res_valid), 32'd0);
        chk("mid_rst_queue_empty", 32'(q.size()), 32'd0);
        run_frame(3, 5, 1);
        end_frame(0, 0, "after_rst");
        do_ack("after_rst_ack");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
